// File: rtl/mul12_pp_sched.sv
// 12x12 unsigned mantissa multiplier controller.
// Runs four partial products through one shared 6x6 multiplier.
module mul12_pp_sched #(
  parameter int HALF_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2*HALF_W-1:0]   a,
  input  logic [2*HALF_W-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*HALF_W-1:0]   product,
  output logic [HALF_W-1:0]     mul_a,
  output logic [HALF_W-1:0]     mul_b,
  input  logic [2*HALF_W-1:0]   mul_out
);

  localparam int OW = 2 * HALF_W;
  localparam int PW = 4 * HALF_W;

  typedef enum logic [2:0] {
    IDLE,
    P0,
    P1,
    P2,
    P3,
    DONE
  } state_e;

  state_e          state_q;
  logic [OW-1:0]   a_q;
  logic [OW-1:0]   b_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   product_q;
  logic            busy_q;
  logic            done_q;

  logic [HALF_W-1:0] al;
  logic [HALF_W-1:0] ah;
  logic [HALF_W-1:0] bl;
  logic [HALF_W-1:0] bh;
  logic [PW-1:0]     pp;
  logic [PW-1:0]     pp_sh;
  logic [PW-1:0]     acc_d;

  assign al = a_q[HALF_W-1:0];
  assign ah = a_q[OW-1:HALF_W];
  assign bl = b_q[HALF_W-1:0];
  assign bh = b_q[OW-1:HALF_W];

  assign pp    = {{OW{1'b0}}, mul_out};
  assign acc_d = acc_q + pp_sh;

  // Operand select for the shared multiplier; idle states drive zero.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      P0: begin
        mul_a = al;
        mul_b = bl;
      end
      P1: begin
        mul_a = al;
        mul_b = bh;
      end
      P2: begin
        mul_a = ah;
        mul_b = bl;
      end
      P3: begin
        mul_a = ah;
        mul_b = bh;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  // Weight the current partial product by its position.
  always_comb begin
    pp_sh = pp;
    unique case (state_q)
      P1, P2:  pp_sh = pp << HALF_W;
      P3:      pp_sh = pp << OW;
      default: pp_sh = pp;
    endcase
  end

  // Schedule FSM with accumulator and registered status/result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= P0;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        P0: begin
          acc_q   <= acc_d;
          state_q <= P1;
        end
        P1: begin
          acc_q   <= acc_d;
          state_q <= P2;
        end
        P2: begin
          acc_q   <= acc_d;
          state_q <= P3;
        end
        P3: begin
          product_q <= acc_d;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= DONE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mul12_pp_sched.sv
// Directed and random bench for mul12_pp_sched.
// A behavioural 6x6 multiplier stands in for the shared unit.
module tb_mul12_pp_sched;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] a;
  logic [11:0] b;
  logic        busy;
  logic        done;
  logic [23:0] product;
  logic [5:0]  mul_a;
  logic [5:0]  mul_b;
  logic [11:0] mul_out;

  int checks;
  int failures;

  mul12_pp_sched #(.HALF_W(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_out (mul_out)
  );

  // Garbage outside the busy window exposes any stray use of mul_out.
  assign mul_out = busy ? ({6'b0, mul_a} * {6'b0, mul_b}) : 12'hA5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] va;
    logic [11:0] vb;
    logic [23:0] vp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // One operation: checks latency, busy window, result hold and result.
  task automatic do_op(input logic [11:0] ta, input logic [11:0] tb_v,
                       input logic [23:0] exp, input string nm);
    logic [23:0] prev;
    int          k;
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    prev  = product;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({nm, "_busy_p0"}, {31'b0, busy}, 32'd1);
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        k = i;
        break;
      end
      chk({nm, "_hold"}, {8'b0, product}, {8'b0, prev});
    end
    chk({nm, "_lat"}, k, 4);
    chk({nm, "_prod"}, {8'b0, product}, {8'b0, exp});
    chk({nm, "_busy_done"}, {31'b0, busy}, 32'd0);
    chk({nm, "_mulz"}, {20'b0, mul_a, mul_b}, 32'd0);
  endtask

  initial begin
    logic [11:0] ea;
    logic [11:0] eb;
    logic        seen;
    checks   = 0;
    failures = 0;

    vecs[0] = '{12'h00C, 12'h012, 24'h0000D8};
    vecs[1] = '{12'h040, 12'h041, 24'h001040};
    vecs[2] = '{12'hFFF, 12'hFFF, 24'hFFE001};
    vecs[3] = '{12'h000, 12'hFFF, 24'h000000};
    vecs[4] = '{12'h001, 12'h001, 24'h000001};
    vecs[5] = '{12'h800, 12'h800, 24'h400000};
    vecs[6] = '{12'hABC, 12'h123, 24'h0C33B4};
    vecs[7] = '{12'h03F, 12'hFC0, 24'h03E040};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_prod", {8'b0, product}, 32'd0);
    chk("rst_mul", {20'b0, mul_a, mul_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vp, $sformatf("vec%0d", i));
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_done_1cyc", i), {31'b0, done}, 32'd0);
    end

    // Start held high, operands changing every cycle
    idle(2);
    ea = '0;
    eb = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      start = 1'b1;
      a = 12'h100 + 12'(n);
      b = 12'h0F0 + 12'(3 * n);
      if (n % 5 == 0) begin
        ea = a;
        eb = b;
      end
      @(posedge clk);
      #1;
      if (n % 5 == 4) begin
        chk("b2b_done", {31'b0, done}, 32'd1);
        chk("b2b_prod", {8'b0, product}, {8'b0, 24'(ea) * 24'(eb)});
      end else begin
        chk("b2b_nodone", {31'b0, done}, 32'd0);
      end
    end
    idle(3);

    // Start during P1 with other operands is ignored
    @(negedge clk);
    a = 12'h00C;
    b = 12'h012;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    a = 12'hFFF;
    b = 12'hFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("ign_nodone_p3", {31'b0, done}, 32'd0);
    @(posedge clk);
    #1;
    chk("ign_done", {31'b0, done}, 32'd1);
    chk("ign_prod", {8'b0, product}, 32'h0000D8);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("ign_no_extra_done", {31'b0, seen}, 32'd0);

    // Reset during P2
    @(negedge clk);
    a = 12'hABC;
    b = 12'h123;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("p2_mul_a", {26'b0, mul_a}, 32'h2A);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_prod", {8'b0, product}, 32'd0);
    chk("arst_mul", {20'b0, mul_a, mul_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    chk("arst_quiet", {31'b0, seen}, 32'd0);
    do_op(12'hABC, 12'h123, 24'h0C33B4, "arst_fresh");

    // Random sweep, back to back from DONE
    for (int i = 0; i < 1000; i++) begin
      ea = 12'($urandom);
      eb = 12'($urandom);
      do_op(ea, eb, 24'(ea) * 24'(eb), "rnd");
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
